// File: rtl/axis_width_conv_pkg.sv
// Shared definitions for the narrow/wide stream width converters.
package axis_width_conv_pkg;

    // Width of the accepted-bit counter exposed by both converters.
    localparam int BIT_COUNT_W = 16;

    // Legal geometry: the wide word must be a whole multiple (at least 2) of the narrow word.
    function automatic bit width_ok(input int m, input int n);
        if (m <= 0) return 1'b0;
        if ((n % m) != 0) return 1'b0;
        return (n / m) >= 2;
    endfunction

    // No completed slot is waiting: write and read pointers coincide.
    function automatic logic is_empty(input logic wr_page, input logic wr_ext,
                                      input logic rd_page, input logic rd_ext);
        return (wr_ext == rd_ext) && (wr_page == rd_page);
    endfunction

    // Both slots hold completed, unread words: writer is a full lap ahead.
    function automatic logic is_full(input logic wr_page, input logic wr_ext,
                                     input logic rd_page, input logic rd_ext);
        return (wr_ext != rd_ext) && (wr_page == rd_page);
    endfunction

endpackage

// File: rtl/axis_width_conv_narrow_wide.sv
// Narrow-to-wide stream width converter: packs K = N/M narrow words into one
// wide word, most-significant lane first, through a two-slot page buffer.
module axis_width_conv_narrow_wide
    import axis_width_conv_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   s_axis_tnext,
    input  logic [M-1:0]           s_axis_tdata,
    input  logic                   s_axis_tfirst,
    input  logic                   s_axis_tvalid,
    input  logic                   m_axis_tnext,
    output logic [N-1:0]           m_axis_tdata,
    output logic                   m_axis_tfirst,
    output logic                   m_axis_tvalid,
    output logic [BIT_COUNT_W-1:0] bit_count
);

    localparam int K  = N / M;
    localparam int LW = (K > 1) ? $clog2(K) : 1;
    localparam logic [LW-1:0] LANE_TOP  = LW'(K - 1);
    localparam logic [LW-1:0] LANE_NEXT = LW'(K - 2);

    if (!width_ok(M, N)) begin : g_width_err
        $error("axis_width_conv_narrow_wide: N must be a multiple of M with N/M >= 2");
    end

    // Page pointers behave as a 2-bit counter {ext, page}; ext disambiguates full from empty.
    typedef struct packed {
        logic [1:0][N-1:0]      data;
        logic [1:0]             first;
        logic                   wr_page;
        logic                   wr_ext;
        logic [LW-1:0]          wr_lane;
        logic                   rd_page;
        logic                   rd_ext;
        logic [BIT_COUNT_W-1:0] bit_count;
    } regs_t;

    regs_t r;
    regs_t nxt;

    logic full;
    logic empty;
    logic mid_first;
    logic accept_norm;
    logic accept_mid;
    logic rd_fire;
    int   lane_lo;

    // Next-state and output logic; input acceptance depends only on registered state and source inputs.
    always_comb begin
        nxt         = r;
        full        = is_full(r.wr_page, r.wr_ext, r.rd_page, r.rd_ext);
        empty       = is_empty(r.wr_page, r.wr_ext, r.rd_page, r.rd_ext);
        mid_first   = s_axis_tvalid && s_axis_tfirst && (r.wr_lane != LANE_TOP);
        accept_norm = s_axis_tvalid && !full && !mid_first;
        accept_mid  = mid_first && empty;
        rd_fire     = m_axis_tnext && !empty;
        lane_lo     = int'(r.wr_lane) * M;

        s_axis_tnext  = !rst && (accept_norm || accept_mid);
        m_axis_tvalid = !empty;
        m_axis_tdata  = r.data[r.rd_page];
        m_axis_tfirst = r.first[r.rd_page] && !empty;
        bit_count     = r.bit_count;

        if (accept_norm) begin
            if (r.wr_lane == LANE_TOP) begin
                nxt.data[r.wr_page]  = {s_axis_tdata, {(N-M){1'b0}}};
                nxt.first[r.wr_page] = s_axis_tfirst;
            end else begin
                nxt.data[r.wr_page][lane_lo +: M] = s_axis_tdata;
            end
            if (r.wr_lane == '0) begin
                {nxt.wr_ext, nxt.wr_page} = {r.wr_ext, r.wr_page} + 2'd1;
                nxt.wr_lane = LANE_TOP;
            end else begin
                nxt.wr_lane = r.wr_lane - 1'b1;
            end
            nxt.bit_count = r.bit_count + BIT_COUNT_W'(M);
        end else if (accept_mid) begin
            // Close the partial slot as-is (its unwritten lanes are already zero) and start the other one.
            nxt.data[!r.wr_page]  = {s_axis_tdata, {(N-M){1'b0}}};
            nxt.first[!r.wr_page] = 1'b1;
            {nxt.wr_ext, nxt.wr_page} = {r.wr_ext, r.wr_page} + 2'd1;
            nxt.wr_lane   = LANE_NEXT;
            nxt.bit_count = r.bit_count + BIT_COUNT_W'(M);
        end

        if (rd_fire) begin
            {nxt.rd_ext, nxt.rd_page} = {r.rd_ext, r.rd_page} + 2'd1;
        end
    end

    // State register; reset discards partial groups and unread words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r         <= '0;
            r.wr_lane <= LANE_TOP;
        end else begin
            r <= nxt;
        end
    end

endmodule

// File: tb/tb_axis_width_conv_narrow_wide.sv
// Self-checking bench for axis_width_conv_narrow_wide (M=4, N=8) with an output scoreboard.
module tb_axis_width_conv_narrow_wide;

    localparam int M = 4;
    localparam int N = 8;
    localparam int K = N / M;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_axis_tnext;
    logic [M-1:0] s_axis_tdata;
    logic         s_axis_tfirst;
    logic         s_axis_tvalid;
    logic         m_axis_tnext;
    logic [N-1:0] m_axis_tdata;
    logic         m_axis_tfirst;
    logic         m_axis_tvalid;
    logic [15:0]  bit_count;

    typedef struct packed {
        logic [N-1:0] data;
        logic         first;
    } exp_t;

    exp_t         sb[$];
    exp_t         e_pop;
    exp_t         e_push;
    int           assert_count = 0;
    int           fail_count   = 0;
    int           sink_mode    = 3;
    int           out_count    = 0;
    int           out_mark;
    logic [N-1:0] last_data    = '0;
    logic         last_first   = 1'b0;
    int           mlane        = K - 1;
    logic [N-1:0] mword        = '0;
    logic         mfirst       = 1'b0;

    axis_width_conv_narrow_wide #(.M(M), .N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tnext  (s_axis_tnext),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tfirst (s_axis_tfirst),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tnext  (m_axis_tnext),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tfirst (m_axis_tfirst),
        .m_axis_tvalid (m_axis_tvalid),
        .bit_count     (bit_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Packing model: one accepted narrow word, MS lane first, early close on a mid-group first flag.
    task automatic modelAccept(input logic [M-1:0] d, input logic f);
        if (f && mlane != K - 1) begin
            e_push.data  = mword;
            e_push.first = mfirst;
            sb.push_back(e_push);
            mlane = K - 1;
        end
        if (mlane == K - 1) begin
            mword  = '0;
            mfirst = f;
        end
        mword[mlane*M +: M] = d;
        if (mlane == 0) begin
            e_push.data  = mword;
            e_push.first = mfirst;
            sb.push_back(e_push);
            mlane = K - 1;
        end else begin
            mlane--;
        end
    endtask

    // Sink driver: 0 never reads, 1 always reads, 2 random back-pressure, 3 manual.
    always @(posedge clk) begin
        #1;
        case (sink_mode)
            0:       m_axis_tnext = 1'b0;
            1:       m_axis_tnext = 1'b1;
            2:       m_axis_tnext = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Monitor: feed accepted inputs to the model and compare every output transfer.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mlane  = K - 1;
            mword  = '0;
            mfirst = 1'b0;
        end else begin
            if (m_axis_tnext && m_axis_tvalid) begin
                out_count++;
                last_data  = m_axis_tdata;
                last_first = m_axis_tfirst;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", 1, 0);
                end else begin
                    e_pop = sb.pop_front();
                    checkOutput("out_data", 32'(m_axis_tdata), 32'(e_pop.data));
                    checkOutput("out_first", 32'(m_axis_tfirst), 32'(e_pop.first));
                end
            end
            if (s_axis_tnext && s_axis_tvalid) modelAccept(s_axis_tdata, s_axis_tfirst);
        end
    end

    task automatic applyStimulus(input logic [M-1:0] d, input logic f);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tfirst = f;
        while (!ok && n < 40) begin
            @(negedge clk);
            if (s_axis_tnext) ok = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tfirst = 1'b0;
        if (!ok) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic drainOutput(input string tag);
        int n;
        n = 0;
        sink_mode = 1;
        @(negedge clk);
        while ((sb.size() != 0 || m_axis_tvalid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drained"}, 32'(n < 50), 1);
        @(posedge clk);
        #1;
        sink_mode    = 0;
        m_axis_tnext = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 4'h1;
        s_axis_tfirst = 1'b1;
        m_axis_tnext  = 1'b0;
        sink_mode     = 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tnext", 32'(s_axis_tnext), 0);
        checkOutput("rst_tvalid", 32'(m_axis_tvalid), 0);
        checkOutput("rst_tdata", 32'(m_axis_tdata), 0);
        checkOutput("rst_tfirst", 32'(m_axis_tfirst), 0);
        checkOutput("rst_bitcount", 32'(bit_count), 0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tfirst = 1'b0;
        sink_mode     = 0;

        // Basic pack: 0xA then 0x5 gives 0xA5 one cycle after the second accept.
        applyStimulus(4'hA, 1'b1);
        applyStimulus(4'h5, 1'b0);
        @(negedge clk);
        checkOutput("pack_tvalid", 32'(m_axis_tvalid), 1);
        checkOutput("pack_tdata", 32'(m_axis_tdata), 32'hA5);
        checkOutput("pack_tfirst", 32'(m_axis_tfirst), 1);
        @(posedge clk);
        #1;
        drainOutput("pack");

        // Fill both slots with no reader, stall, then resume after one read.
        out_mark  = out_count;
        sink_mode = 3;
        for (int i = 1; i <= 4; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 4'(i);
            s_axis_tfirst = (i == 1);
            @(negedge clk);
            checkOutput("fill_tnext", 32'(s_axis_tnext), 1);
            @(posedge clk);
            #1;
        end
        s_axis_tdata  = 4'h5;
        s_axis_tfirst = 1'b0;
        @(negedge clk);
        checkOutput("full_stall", 32'(s_axis_tnext), 0);
        checkOutput("full_tdata", 32'(m_axis_tdata), 32'h12);
        @(posedge clk);
        #1;
        m_axis_tnext = 1'b1;
        @(negedge clk);
        checkOutput("no_sink_path", 32'(s_axis_tnext), 0);
        checkOutput("hold_tdata", 32'(m_axis_tdata), 32'h12);
        @(posedge clk);
        #1;
        m_axis_tnext = 1'b0;
        @(negedge clk);
        checkOutput("full_resume", 32'(s_axis_tnext), 1);
        @(posedge clk);
        #1;
        s_axis_tdata = 4'h6;
        @(negedge clk);
        checkOutput("six_accept", 32'(s_axis_tnext), 1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        drainOutput("full");
        checkOutput("full_outcount", 32'(out_count - out_mark), 3);
        checkOutput("full_last", 32'(last_data), 32'h56);

        // Mid-group first flag on an empty buffer closes the partial word early.
        out_mark = out_count;
        applyStimulus(4'h3, 1'b1);
        applyStimulus(4'h7, 1'b1);
        applyStimulus(4'h9, 1'b0);
        drainOutput("early");
        checkOutput("early_outcount", 32'(out_count - out_mark), 2);
        checkOutput("early_last", 32'(last_data), 32'h79);
        checkOutput("early_lastfirst", 32'(last_first), 1);

        // Mid-group first flag while one word is waiting stalls until that word is read.
        out_mark  = out_count;
        sink_mode = 3;
        applyStimulus(4'h1, 1'b1);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h3, 1'b1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 4'h4;
        s_axis_tfirst = 1'b1;
        @(negedge clk);
        checkOutput("mid_stall", 32'(s_axis_tnext), 0);
        @(posedge clk);
        #1;
        m_axis_tnext = 1'b1;
        @(negedge clk);
        checkOutput("mid_stall_rd", 32'(s_axis_tnext), 0);
        @(posedge clk);
        #1;
        m_axis_tnext = 1'b0;
        @(negedge clk);
        checkOutput("mid_resume", 32'(s_axis_tnext), 1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tfirst = 1'b0;
        applyStimulus(4'h5, 1'b0);
        drainOutput("mid");
        checkOutput("mid_outcount", 32'(out_count - out_mark), 3);
        checkOutput("mid_last", 32'(last_data), 32'h45);

        // Reset mid-group discards the partial word.
        applyStimulus(4'hC, 1'b1);
        rst           = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 4'hE;
        s_axis_tfirst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_tnext", 32'(s_axis_tnext), 0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_tvalid", 32'(m_axis_tvalid), 0);
        checkOutput("rst_mid_bitcount", 32'(bit_count), 0);
        @(posedge clk);
        #1;
        out_mark = out_count;
        applyStimulus(4'h1, 1'b1);
        applyStimulus(4'h2, 1'b0);
        drainOutput("rstmid");
        checkOutput("rstmid_outcount", 32'(out_count - out_mark), 1);
        checkOutput("rstmid_last", 32'(last_data), 32'h12);
        checkOutput("rstmid_bitcount", 32'(bit_count), 8);

        // Random back-pressure and input gaps over ten words.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_mark  = out_count;
        sink_mode = 2;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(4'($urandom_range(0, 15)), (i == 0));
        end
        drainOutput("rand");
        checkOutput("rand_bitcount", 32'(bit_count), 40);
        checkOutput("rand_outcount", 32'(out_count - out_mark), 5);
        checkOutput("rand_sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
